nw_align_emitter: RTL and testbench



---
 rtl/nw_align_emitter_if.sv | 35 +++
 rtl/nw_align_emitter.sv | 239 +++++++++++++++++++++++
 tb/tb_nw_align_emitter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nw_align_emitter_if.sv
// Handshake bundle between the traceback grid, the emitter and the column sink.
interface nw_align_emitter_if #(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CORD_LENGTH = 8
);
    logic [LENGTH*CWIDTH-1:0] s1;
    logic [LENGTH*CWIDTH-1:0] s2;
    logic                     in_valid;
    logic                     in_ready;
    logic [CORD_LENGTH-1:0]   in_x;
    logic [CORD_LENGTH-1:0]   in_y;
    logic                     out_valid;
    logic                     out_ready;
    logic [CWIDTH-1:0]        out_c1;
    logic [CWIDTH-1:0]        out_c2;
    logic                     out_gap1;
    logic                     out_gap2;
    logic                     out_last;
    logic [SWIDTH-1:0]        score;
    logic                     err;

    modport master (
        output s1, s2, in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_c1, out_c2,
        input  out_gap1, out_gap2, out_last, score, err
    );

    modport slave (
        input  s1, s2, in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_c1, out_c2,
        output out_gap1, out_gap2, out_last, score, err
    );
endinterface

// File: rtl/nw_align_emitter.sv
// Checks the NW traceback stream, stacks one column per cell, emits forward.
// Define NW_EMIT_SCORE_EN to accumulate the alignment score on each push.
module nw_align_emitter #(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CORD_LENGTH = 8,
    parameter int MATCH       = 1,
    parameter int MISMATCH    = -1,
    parameter int INDEL       = -1
) (
    input logic               clk,
    input logic               reset,
    nw_align_emitter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_TERM, S_EMIT, S_ERROR
    } state_e;

    localparam int DEPTH = 2 * LENGTH - 1;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int EW    = 2 * CWIDTH + 2;
    localparam int SW    = LENGTH * CWIDTH;
    localparam logic [CORD_LENGTH-1:0] LASTC = CORD_LENGTH'(LENGTH - 1);
    localparam logic [CORD_LENGTH-1:0] LIM   = CORD_LENGTH'(LENGTH);
    localparam logic [CORD_LENGTH-1:0] ONEC  = CORD_LENGTH'(1);
    localparam logic [PW-1:0]          FULL  = PW'(DEPTH);
    localparam logic [PW-1:0]          ONEP  = PW'(1);

    state_e                 state_q, state_d;
    logic [SW-1:0]          s1_q, s1_d, s2_q, s2_d;
    logic [CORD_LENGTH-1:0] px_q, px_d, py_q, py_d;
    logic [PW-1:0]          sp_q, sp_d;
    logic [EW-1:0]          stk_q [DEPTH];
    logic                   ov_q, ov_d, ol_q, ol_d;
    logic                   g1_q, g1_d, g2_q, g2_d;
    logic                   err_q, err_d;
    logic [CWIDTH-1:0]      c1_q, c1_d, c2_q, c2_d;

    logic                   acc, is_start, is_org, in_rng;
    logic                   st_diag, st_top, st_left, legal;
    logic                   push, ovf, pop, fin, in_ready;
    logic [CORD_LENGTH-1:0] pxm, pym;
    logic [PW-1:0]          top_idx;
    logic [EW-1:0]          push_e, pop_e;

    function automatic logic [CWIDTH-1:0] chr(
        input logic [SW-1:0]          s,
        input logic [CORD_LENGTH-1:0] i
    );
        logic [CWIDTH-1:0] c;
        c = '0;
        for (int k = 0; k < LENGTH; k++)
            if (i == CORD_LENGTH'(k))
                c = s[(LENGTH-1-k)*CWIDTH +: CWIDTH];
        return c;
    endfunction

    assign acc      = bus.in_valid && in_ready;
    assign is_start = bus.in_x == LASTC && bus.in_y == LASTC;
    assign is_org   = bus.in_x == '0 && bus.in_y == '0;
    assign in_rng   = bus.in_x < LIM && bus.in_y < LIM;
    assign pxm      = px_q - ONEC;
    assign pym      = py_q - ONEC;

    // Zero guards stop the decrement wrapping into a fake legal step.
    assign st_diag = in_rng && px_q != '0 && py_q != '0 &&
                     bus.in_x == pxm && bus.in_y == pym;
    assign st_top  = in_rng && py_q != '0 &&
                     bus.in_x == px_q && bus.in_y == pym;
    assign st_left = in_rng && px_q != '0 &&
                     bus.in_x == pxm && bus.in_y == py_q;
    assign legal   = st_diag || st_top || st_left;

    always_comb begin
        push   = 1'b0;
        push_e = '0;
        if (state_q == S_COLLECT && acc && legal) begin
            push = 1'b1;
            unique case (1'b1)
                st_diag: push_e = {2'b00, chr(s1_q, py_q), chr(s2_q, px_q)};
                st_top:  push_e = {2'b01, chr(s1_q, py_q), {CWIDTH{1'b0}}};
                default: push_e = {2'b10, {CWIDTH{1'b0}}, chr(s2_q, px_q)};
            endcase
        end else if (state_q == S_TERM) begin
            push   = 1'b1;
            push_e = {2'b00, chr(s1_q, '0), chr(s2_q, '0)};
        end
    end

    assign ovf     = push && sp_q == FULL;
    assign top_idx = (sp_q != '0) ? sp_q - ONEP : '0;
    assign pop_e   = stk_q[top_idx];
    assign pop     = state_q == S_EMIT && sp_q != '0 &&
                     (!ov_q || (bus.out_ready && !ol_q));
    assign fin     = state_q == S_EMIT && ov_q && bus.out_ready && ol_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (acc) state_d = is_start ? S_COLLECT : S_ERROR;
            S_COLLECT:
                if (acc) begin
                    if (!legal || ovf) state_d = S_ERROR;
                    else if (is_org)   state_d = S_TERM;
                end
            S_TERM:  state_d = ovf ? S_ERROR : S_EMIT;
            S_EMIT:  if (fin) state_d = S_IDLE;
            S_ERROR: if (acc && is_org) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = state_q == S_IDLE || state_q == S_COLLECT ||
                   state_q == S_ERROR;
    end

    always_comb begin
        s1_d  = s1_q;
        s2_d  = s2_q;
        px_d  = px_q;
        py_d  = py_q;
        sp_d  = sp_q;
        err_d = err_q;
        ov_d  = ov_q;
        ol_d  = ol_q;
        g1_d  = g1_q;
        g2_d  = g2_q;
        c1_d  = c1_q;
        c2_d  = c2_q;
        if (state_q == S_IDLE && acc) begin
            if (is_start) begin
                s1_d = bus.s1;
                s2_d = bus.s2;
                px_d = bus.in_x;
                py_d = bus.in_y;
                sp_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (state_q == S_COLLECT && acc && legal && !ovf) begin
            px_d = bus.in_x;
            py_d = bus.in_y;
        end
        if ((state_q == S_COLLECT && acc && !legal) || ovf)
            err_d = 1'b1;
        if (push && !ovf)
            sp_d = sp_q + ONEP;
        if (state_q == S_ERROR && acc && is_org)
            sp_d = '0;
        // Bottom entry is the (LENGTH-1, LENGTH-1) column, i.e. the last one out.
        if (pop) begin
            sp_d = sp_q - ONEP;
            ov_d = 1'b1;
            ol_d = sp_q == ONEP;
            {g1_d, g2_d, c1_d, c2_d} = pop_e;
        end else if (fin) begin
            ov_d = 1'b0;
            ol_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            px_q  <= '0;
            py_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
            ov_q  <= 1'b0;
            ol_q  <= 1'b0;
            g1_q  <= 1'b0;
            g2_q  <= 1'b0;
            c1_q  <= '0;
            c2_q  <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            px_q  <= px_d;
            py_q  <= py_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            ov_q  <= ov_d;
            ol_q  <= ol_d;
            g1_q  <= g1_d;
            g2_q  <= g2_d;
            c1_q  <= c1_d;
            c2_q  <= c2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !ovf) stk_q[sp_q] <= push_e;
    end

`ifdef NW_EMIT_SCORE_EN
    logic [SWIDTH-1:0] score_q, score_d, w;

    always_comb begin
        w = SWIDTH'(MISMATCH);
        if (push_e[EW-1] || push_e[EW-2])
            w = SWIDTH'(INDEL);
        else if (push_e[2*CWIDTH-1:CWIDTH] == push_e[CWIDTH-1:0])
            w = SWIDTH'(MATCH);
        score_d = score_q;
        if (state_q == S_IDLE && acc) score_d = '0;
        else if (push && !ovf)        score_d = score_q + w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) score_q <= '0;
        else       score_q <= score_d;
    end

    assign bus.score = score_q;
`else
    logic unused_w;
    assign unused_w  = ^{SWIDTH, MATCH, MISMATCH, INDEL};
    assign bus.score = '0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.out_last  = ol_q;
    assign bus.out_gap1  = g1_q;
    assign bus.out_gap2  = g2_q;
    assign bus.out_c1    = c1_q;
    assign bus.out_c2    = c2_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_nw_align_emitter.sv
// Directed bench for nw_align_emitter with LENGTH=4 and s1=s2=8'h1B.
module tb_nw_align_emitter;
    localparam int L  = 4;
    localparam int CW = 2;
    localparam int SW = 16;
    localparam int CL = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nw_align_emitter_if #(
        .LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL)
    ) bus ();

    nw_align_emitter #(
        .LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nvec;
    int nbad;
    int first_c;
    int end_c;
    int exp_score;
    logic [6:0] exp_col [8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] col(input logic g1, input logic g2,
                                       input logic [1:0] a,
                                       input logic [1:0] b,
                                       input logic l);
        return {g1, g2, a, b, l};
    endfunction

    function automatic logic [6:0] seen();
        return {bus.out_gap1, bus.out_gap2, bus.out_c1, bus.out_c2,
                bus.out_last};
    endfunction

    task automatic send(input int x, input int y);
        bus.in_valid = 1'b1;
        bus.in_x = CL'(x);
        bus.in_y = CL'(y);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic diag_path();
        send(3, 3);
        send(2, 2);
        send(1, 1);
        send(0, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic set_diag();
        for (int i = 0; i < 4; i++)
            exp_col[i] = col(1'b0, 1'b0, 2'(i), 2'(i), i == 3);
`ifdef NW_EMIT_SCORE_EN
        exp_score = 4;
`else
        exp_score = 0;
`endif
    endtask

    task automatic drain(input int n, input int st_at, input int st_len);
        int k;
        int cyc;
        int hold;
        k = 0;
        cyc = 0;
        hold = st_len;
        first_c = -1;
        bus.out_ready = 1'b1;
        while (k < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                if (first_c < 0) first_c = cyc;
                chk($sformatf("col%0d", k), 32'(seen()), 32'(exp_col[k]));
                if (bus.out_last)
                    chk("score", 32'(signed'(bus.score)), 32'(exp_score));
                if (k == st_at && hold > 0) begin
                    hold--;
                    bus.out_ready = 1'b0;
                end else begin
                    bus.out_ready = 1'b1;
                    k++;
                end
            end
        end
        chk("ncols", 32'(k), 32'(n));
        end_c = cyc;
        @(negedge clk);
        chk("done_ov", 32'(bus.out_valid), 32'd0);
        chk("done_rdy", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nvec = 0;
        nbad = 0;
        bus.s1 = 8'h1B;
        bus.s2 = 8'h1B;
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'({bus.out_valid, seen(), bus.err}), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // diagonal path
        set_diag();
        diag_path();
        chk("term_rdy", 32'(bus.in_ready), 32'd0);
        drain(4, -1, 0);
        chk("diag_first", 32'(first_c), 32'd2);
        chk("diag_rate", 32'(end_c), 32'd5);

        // gapped path, strings change after the start coordinate
        exp_col[0] = col(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        exp_col[1] = col(1'b1, 1'b0, 2'd0, 2'd1, 1'b0);
        exp_col[2] = col(1'b0, 1'b0, 2'd1, 2'd2, 1'b0);
        exp_col[3] = col(1'b0, 1'b0, 2'd2, 2'd3, 1'b0);
        exp_col[4] = col(1'b0, 1'b1, 2'd3, 2'd0, 1'b1);
`ifdef NW_EMIT_SCORE_EN
        exp_score = -3;
`else
        exp_score = 0;
`endif
        send(3, 3);
        bus.s1 = 8'h00;
        bus.s2 = 8'hFF;
        send(3, 2);
        send(2, 1);
        send(1, 0);
        send(0, 0);
        bus.in_valid = 1'b0;
        drain(5, -1, 0);
        chk("gap_first", 32'(first_c), 32'd2);
        chk("gap_rate", 32'(end_c), 32'd6);
        bus.s1 = 8'h1B;
        bus.s2 = 8'h1B;

        // backpressure on the second column
        set_diag();
        diag_path();
        drain(4, 1, 3);
        chk("bp_rate", 32'(end_c), 32'd8);

        // reset in the middle of emission
        diag_path();
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_col1", 32'(seen()), 32'(exp_col[1]));
        reset = 1'b1;
        #1;
        chk("mid_rst", 32'({bus.out_valid, seen(), bus.err}), 32'd0);
        chk("mid_score", 32'(bus.score), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        diag_path();
        drain(4, -1, 0);

        // illegal step, then recovery through (0,0)
        send(3, 3);
        send(1, 1);
        bus.in_valid = 1'b0;
        chk("ill_err", 32'(bus.err), 32'd1);
        chk("ill_rdy", 32'(bus.in_ready), 32'd1);
        send(2, 2);
        send(1, 0);
        chk("ill_ov", 32'(bus.out_valid), 32'd0);
        send(0, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("ill_ov2", 32'(bus.out_valid), 32'd0);
        chk("ill_sticky", 32'(bus.err), 32'd1);
        diag_path();
        drain(4, -1, 0);
        chk("ill_sticky2", 32'(bus.err), 32'd1);

        // wrong start coordinate
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ws_clr", 32'(bus.err), 32'd0);
        send(2, 3);
        bus.in_valid = 1'b0;
        chk("ws_err", 32'(bus.err), 32'd1);
        send(3, 3);
        send(0, 0);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ws_ov", 32'(bus.out_valid), 32'd0);
        chk("ws_rdy", 32'(bus.in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
